// File: rtl/router_pkt_tx.sv
// router_pkt_tx
// Builds one packet per start request and sends it to a router port.
// A packet is a header byte {len, addr}, then len payload bytes, then an
// even-parity byte (header XOR every payload byte). The payload is first
// collected from the upstream source into a local 64x8 buffer. It is then
// replayed toward the router one byte at a time, with busy back-pressure.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   i_start      one-cycle packet request, looked at only while idle
//   i_dest_addr  destination port 0..2 (3 is rejected)
//   i_pld_len    payload length 1..63 (0 is rejected)
//   i_pld_data   upstream payload byte
//   i_pld_valid  upstream byte valid
//   o_pld_ready  block takes an upstream byte this cycle
//   i_busy       router cannot take the presented byte this cycle
//   o_pkt_valid  high for header and payload bytes, low for the parity byte
//   o_data_out   byte presented to the router
//   o_tx_active  block is busy with a packet
//   o_done       one-cycle pulse after the parity byte has been taken
//   o_err        one-cycle pulse after a rejected start
//
// state   | meaning
// IDLE    | waiting for start; outputs quiet
// FILL    | collecting len payload bytes into the buffer
// HEADER  | presenting {len, addr} until the router takes it
// PAYLOAD | replaying buffer bytes in order
// PARITY  | presenting the parity byte (pkt_valid low)
module router_pkt_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [1:0] i_dest_addr,
    input  logic [5:0] i_pld_len,
    input  logic [7:0] i_pld_data,
    input  logic       i_pld_valid,
    output logic       o_pld_ready,
    input  logic       i_busy,
    output logic       o_pkt_valid,
    output logic [7:0] o_data_out,
    output logic       o_tx_active,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [5:0]  r_len;
    logic [1:0]  r_addr;
    logic [5:0]  r_wptr;
    logic [5:0]  r_rptr;
    logic [7:0]  r_parity;
    logic        r_done;
    logic        r_err;
    logic [7:0]  r_buf [0:63];

    logic [7:0]  w_header;
    logic        w_legal;
    logic        w_accept_start;
    logic        w_bad_start;
    logic        w_wr_en;
    logic        w_hdr_sent;
    logic        w_rd_adv;
    logic        w_pkt_end;

    assign w_header = {r_len, r_addr};
    assign w_legal  = (i_pld_len != 6'd0) && (i_dest_addr != 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        o_pld_ready    = 1'b0;
        o_pkt_valid    = 1'b0;
        o_data_out     = 8'h00;
        o_tx_active    = 1'b1;
        w_accept_start = 1'b0;
        w_bad_start    = 1'b0;
        w_wr_en        = 1'b0;
        w_hdr_sent     = 1'b0;
        w_rd_adv       = 1'b0;
        w_pkt_end      = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_tx_active = 1'b0;
                if (i_start) begin
                    if (w_legal) begin
                        w_accept_start = 1'b1;
                        w_state_nxt    = S_FILL;
                    end else begin
                        w_bad_start = 1'b1;
                    end
                end
            end
            S_FILL: begin
                o_pld_ready = 1'b1;
                w_wr_en     = i_pld_valid;
                if (i_pld_valid && (r_wptr == r_len - 6'd1)) begin
                    w_state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                o_pkt_valid = 1'b1;
                o_data_out  = w_header;
                if (!i_busy) begin
                    w_hdr_sent  = 1'b1;
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                o_pkt_valid = 1'b1;
                o_data_out  = r_buf[r_rptr];
                if (!i_busy) begin
                    w_rd_adv = 1'b1;
                    if (r_rptr == r_len - 6'd1) begin
                        w_state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                o_data_out = r_parity;
                if (!i_busy) begin
                    w_pkt_end   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                o_tx_active = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Parity accumulates payload bytes during FILL and the header once it is
    // taken, so it is complete by the time PARITY is entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_len    <= 6'd0;
            r_addr   <= 2'd0;
            r_wptr   <= 6'd0;
            r_rptr   <= 6'd0;
            r_parity <= 8'h00;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_pkt_end;
            r_err  <= w_bad_start;
            if (w_accept_start) begin
                r_len    <= i_pld_len;
                r_addr   <= i_dest_addr;
                r_wptr   <= 6'd0;
                r_rptr   <= 6'd0;
                r_parity <= 8'h00;
            end
            if (w_wr_en) begin
                r_wptr   <= r_wptr + 6'd1;
                r_parity <= r_parity ^ i_pld_data;
            end
            if (w_hdr_sent) begin
                r_parity <= r_parity ^ w_header;
            end
            if (w_rd_adv) begin
                r_rptr <= r_rptr + 6'd1;
            end
        end
    end

    // Buffer is never cleared; every location read in PAYLOAD was written
    // during the FILL of the same packet.
    always_ff @(posedge clk) begin
        if (rst && w_wr_en) begin
            r_buf[r_wptr] <= i_pld_data;
        end
    end

    assign o_done = r_done;
    assign o_err  = r_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Testbench for router_pkt_tx.
// Each packet is expanded into its expected byte stream (header, payload,
// XOR parity). The driver walks that stream alongside its own random
// valid-gap and busy patterns, and it publishes the expected outputs for
// every cycle. A negedge process compares the DUT against those values.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic [1:0] i_dest_addr;
    logic [5:0] i_pld_len;
    logic [7:0] i_pld_data;
    logic       i_pld_valid;
    logic       o_pld_ready;
    logic       i_busy;
    logic       o_pkt_valid;
    logic [7:0] o_data_out;
    logic       o_tx_active;
    logic       o_done;
    logic       o_err;

    always #5 clk = ~clk;

    router_pkt_tx dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_dest_addr (i_dest_addr),
        .i_pld_len   (i_pld_len),
        .i_pld_data  (i_pld_data),
        .i_pld_valid (i_pld_valid),
        .o_pld_ready (o_pld_ready),
        .i_busy      (i_busy),
        .o_pkt_valid (o_pkt_valid),
        .o_data_out  (o_data_out),
        .o_tx_active (o_tx_active),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;

    logic       exp_pr, exp_pv, exp_ta, exp_done, exp_err;
    logic [7:0] exp_do;
    logic       pend_done = 1'b0;
    logic       pend_err  = 1'b0;

    logic [7:0] pay [0:62];
    logic [7:0] st  [0:64];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pld_ready", {7'd0, o_pld_ready}, {7'd0, exp_pr});
            chk("pkt_valid", {7'd0, o_pkt_valid}, {7'd0, exp_pv});
            chk("data_out",  o_data_out,          exp_do);
            chk("tx_active", {7'd0, o_tx_active}, {7'd0, exp_ta});
            chk("done",      {7'd0, o_done},      {7'd0, exp_done});
            chk("err",       {7'd0, o_err},       {7'd0, exp_err});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for the cycle that has just begun.
    task automatic set_exp(input logic pr, input logic pv, input logic ta, input logic [7:0] d);
        exp_pr    = pr;
        exp_pv    = pv;
        exp_ta    = ta;
        exp_do    = d;
        exp_done  = pend_done;
        exp_err   = pend_err;
        pend_done = 1'b0;
        pend_err  = 1'b0;
    endtask

    task automatic junk_inputs();
        i_dest_addr = 2'($urandom);
        i_pld_len   = 6'($urandom);
        i_pld_data  = 8'($urandom);
        i_pld_valid = 1'($urandom);
        i_busy      = 1'($urandom);
    endtask

    task automatic build_stream(input logic [1:0] addr, input int len);
        logic [7:0] p;
        st[0] = {6'(len), addr};
        p     = st[0];
        for (int i = 0; i < len; i++) begin
            st[i+1] = pay[i];
            p       = p ^ pay[i];
        end
        st[len+1] = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_exp(1'b0, 1'b0, 1'b0, 8'h00);
            rst     = 1'b1;
            i_start = 1'b0;
            junk_inputs();
            tick();
        end
    endtask

    task automatic bad_start(input logic [1:0] addr, input logic [5:0] len);
        set_exp(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        junk_inputs();
        i_start     = 1'b1;
        i_dest_addr = addr;
        i_pld_len   = len;
        tick();
        pend_err = 1'b1;
    endtask

    // Reset asserted during the current cycle; the next cycle must be idle.
    task automatic abort_pkt();
        rst     = 1'b0;
        i_start = 1'($urandom);
        tick();
        rst = 1'b1;
    endtask

    task automatic send_pkt(input logic [1:0] addr, input int len, input int gap_pct,
                            input int busy_pct, input int hold_k, input int hold_n,
                            input int abort_fill, input int abort_k, input logic start_hold);
        int   n;
        int   k;
        int   hc;
        logic v;
        build_stream(addr, len);

        set_exp(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        junk_inputs();
        i_start     = 1'b1;
        i_dest_addr = addr;
        i_pld_len   = 6'(len);
        tick();

        n = 0;
        while (n < len) begin
            set_exp(1'b1, 1'b0, 1'b1, 8'h00);
            junk_inputs();
            i_start     = start_hold;
            v           = ($urandom_range(0, 99) >= gap_pct);
            i_pld_valid = v;
            i_pld_data  = v ? pay[n] : 8'($urandom);
            if (n == abort_fill) begin
                abort_pkt();
                return;
            end
            if (v) n++;
            tick();
        end

        k  = 0;
        hc = 0;
        while (k <= len + 1) begin
            set_exp(1'b0, (k <= len), 1'b1, st[k]);
            junk_inputs();
            i_start = start_hold;
            if (k == hold_k && hc < hold_n) begin
                i_busy = 1'b1;
                hc++;
            end else begin
                i_busy = ($urandom_range(0, 99) < busy_pct);
            end
            if (k == abort_k) begin
                abort_pkt();
                return;
            end
            if (!i_busy) k++;
            tick();
        end
        pend_done = 1'b1;
    endtask

    task automatic rand_payload(input int len);
        for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
    endtask

    initial begin
        int a;
        int l;
        int r;

        rst = 1'b0;
        i_start = 1'b0;
        i_dest_addr = 2'd0;
        i_pld_len = 6'd0;
        i_pld_data = 8'h00;
        i_pld_valid = 1'b0;
        i_busy = 1'b0;
        tick();
        chk_en = 1'b1;

        // Reset held; start must be ignored while rst is low.
        for (int i = 0; i < 3; i++) begin
            set_exp(1'b0, 1'b0, 1'b0, 8'h00);
            rst = 1'b0;
            junk_inputs();
            i_start = 1'($urandom);
            tick();
        end

        // Basic packet, started on the first cycle out of reset.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_pkt(2'd1, 3, 0, 0, -1, 0, -1, -1, 1'b0);
        chk("model_header", st[0], 8'h0D);
        chk("model_parity", st[4], 8'h0D);
        idle(2);

        // Same packet, router busy for 4 cycles while 22 is presented.
        send_pkt(2'd1, 3, 0, 0, 2, 4, -1, -1, 1'b0);
        idle(1);

        // Illegal starts, back to back and alone.
        bad_start(2'd1, 6'd0);
        bad_start(2'd3, 6'd5);
        idle(1);
        bad_start(2'd3, 6'd0);
        idle(2);

        // Shortest packet.
        pay[0] = 8'hA5;
        send_pkt(2'd0, 1, 0, 20, -1, 0, -1, -1, 1'b0);
        idle(1);

        // Longest packet with random valid gaps; illegal start in the done cycle.
        rand_payload(63);
        send_pkt(2'd2, 63, 40, 25, -1, 0, -1, -1, 1'b0);
        chk("model_header_long", st[0], 8'hFE);
        bad_start(2'd3, 6'd3);
        idle(2);

        // Reset during the 2nd payload byte, then a full packet right away.
        rand_payload(5);
        send_pkt(2'd1, 5, 0, 0, -1, 0, -1, 2, 1'b0);
        rand_payload(5);
        send_pkt(2'd2, 5, 20, 20, -1, 0, -1, -1, 1'b0);
        idle(1);

        // Reset mid-fill.
        rand_payload(10);
        send_pkt(2'd0, 10, 30, 0, -1, 0, 3, -1, 1'b0);
        idle(1);

        // start held high throughout: back-to-back packets.
        for (int i = 0; i < 3; i++) begin
            l = $urandom_range(1, 12);
            rand_payload(l);
            send_pkt(2'($urandom_range(0, 2)), l, 20, 20, -1, 0, -1, -1, 1'b1);
        end
        idle(2);

        // Random traffic.
        for (int i = 0; i < 25; i++) begin
            a = $urandom_range(0, 2);
            l = $urandom_range(1, 63);
            rand_payload(l);
            send_pkt(2'(a), l, $urandom_range(0, 50), $urandom_range(0, 50),
                     -1, 0, -1, -1, 1'($urandom));
            r = $urandom_range(0, 4);
            if (r == 1) begin
                if ($urandom_range(0, 1) == 1) bad_start(2'd3, 6'($urandom));
                else                           bad_start(2'($urandom_range(0, 2)), 6'd0);
                idle(1);
            end else if (r > 1) begin
                idle(r - 1);
            end
        end

        idle(3);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 clk  in  1  rising-edge clock; all state updates on posedge clk.
REQ-002 rst  in  1  synchronous reset, active-low; sampled on posedge clk.
REQ-003 start  in  1  single-cycle request to build and send one packet; sampled only in IDLE.
REQ-004 dest_addr  in  2  destination port, 0..2; 3 is illegal.
REQ-005 pld_len  in  6  payload byte count, 1..63; 0 is illegal.
REQ-006 pld_data  in  8  payload byte from the upstream source.
REQ-007 pld_valid  in  1  pld_data valid.
REQ-008 pld_ready  out  1  block accepts a payload byte this cycle.
REQ-009 busy  in  1  router busy; when 1, the presented byte is not taken and SHALL be held.
REQ-010 pkt_valid  out  1  packet valid toward the router; high for header and payload, low for the parity byte.
REQ-011 data_out  out  8  packet byte toward the router.
REQ-012 tx_active  out  1  block is not in IDLE.
REQ-013 done  out  1  one-cycle pulse after the parity byte is accepted.
REQ-014 err  out  1  one-cycle pulse on an illegal start.

Function
REQ-015 The block SHALL implement states IDLE, FILL, HEADER, PAYLOAD and PARITY.
REQ-016 Payload storage SHALL be an internal 64x8 buffer with a 6-bit write pointer (wptr) and a 6-bit read pointer (rptr).
REQ-017 IDLE: start=1 with pld_len!=0 and dest_addr!=3 -> latch len/addr, clear wptr, rptr and parity, go to FILL.
REQ-018 IDLE: start=1 with pld_len==0 or dest_addr==3 -> err=1 on the next cycle only, stay in IDLE, latch nothing.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 FILL: pld_ready=1; on each cycle with pld_valid=1: buf[wptr]<=pld_data, wptr++, parity^=pld_data.
REQ-021 FILL: when the byte with wptr==len-1 is accepted, go to HEADER next cycle; gaps in pld_valid SHALL only stall the fill.
REQ-022 pld_ready SHALL be 0 in every state except FILL.
REQ-023 HEADER: pkt_valid=1, data_out={len[5:0],addr[1:0]}; held while busy=1; on a busy=0 cycle, parity^=header and go to PAYLOAD.
REQ-024 PAYLOAD: pkt_valid=1, data_out=buf[rptr]; on busy=0, rptr++; busy=1 holds rptr and data_out unchanged.
REQ-025 PAYLOAD: when busy=0 and rptr==len-1, go to PARITY next cycle.
REQ-026 pkt_valid SHALL NOT deassert between the header and the last payload byte, even under busy stalls.
REQ-027 PARITY: pkt_valid=0, data_out=parity, where parity = header XOR all payload bytes; held while busy=1.
REQ-028 PARITY: on busy=0, go to IDLE with done=1 for exactly the first IDLE cycle.
REQ-029 IDLE: pkt_valid=0 and data_out=8'h00.
REQ-030 tx_active SHALL be 1 in FILL, HEADER, PAYLOAD and PARITY, and 0 in IDLE.
REQ-031 done and err SHALL be registered pulses and never assert in the same cycle.
REQ-032 A new start in the done cycle (IDLE) SHALL be accepted normally, giving back-to-back packets.

Reset
REQ-033 rst=0 at a clock edge SHALL, in any state including mid-FILL or mid-PAYLOAD: force IDLE; clear wptr, rptr, parity, len and addr; drive pkt_valid=0, data_out=0, pld_ready=0, tx_active=0, done=0, err=0.
REQ-034 Buffer contents need not be reset and SHALL NOT affect outputs before being rewritten.
REQ-035 The first start after reset release SHALL be honoured on the first cycle with rst=1.

Verification
REQ-036 addr=1, len=3, payload 11,22,33, busy=0 -> FILL 3 cycles; then data_out 0D (pv=1), 11, 22, 33 (pv=1), 0D (pv=0); then done pulse.
REQ-037 Same packet with busy=1 for 4 cycles while 22 is presented -> 22 held 5 cycles with pv=1; sequence and parity unchanged.
REQ-038 start with len=0, and separately addr=3 -> err=1 for 1 cycle, tx_active stays 0, no pkt_valid.
REQ-039 addr=2, len=63, random payload with random pld_valid gaps -> header FE, 63 bytes in order, parity equals XOR of all 64 bytes.
REQ-040 rst=0 during the 2nd payload byte -> next cycle IDLE with all outputs 0; a following legal start sends a correct full packet.
REQ-041 start held 1 throughout a packet -> ignored until IDLE; a second packet begins immediately after done.
